fifo_btn_ctrl: RTL
==================

# fifo_btn_ctrl

Upstream front-end for the `cola_fifo` test design: turns the two raw push-buttons (write, read) into debounced, single-cycle `wr`/`rd` strobes, and captures the switch word that is written. Strobes that would overflow a full FIFO or underflow an empty one are suppressed and flagged. The FIFO's `full`/`empty` feed back into this block. Its outputs drive the FIFO's `wr`, `rd` and `in` ports directly.

## Interface
- `N`, 20: debounce counter width; the stable-time window is 2^N clock cycles (about 21 ms at 50 MHz).
- `B`, 3: data word width; matches the FIFO `B`.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_wr`  in  1  raw write button, asynchronous to `clk`, bouncy.
- `btn_rd`  in  1  raw read button, asynchronous, bouncy.
- `sw`  in  B  raw switch word, asynchronous.
- `full`  in  1  FIFO full flag.
- `empty`  in  1  FIFO empty flag.
- `wr`  out  1  one-cycle write strobe to the FIFO.
- `rd`  out  1  one-cycle read strobe to the FIFO.
- `w_data`  out  B  word to write; valid whenever `wr` = 1.
- `wr_drop`  out  1  one-cycle pulse when a write press was suppressed because `full` = 1.
- `rd_drop`  out  1  one-cycle pulse when a read press was suppressed because `empty` = 1.
- `db_wr`, `db_rd`  out  1 each  debounced button levels, for LEDs and debug.

## Operation
- **Synchronisers:** `btn_wr`, `btn_rd` and `sw` each pass through a 2-flop synchroniser. All further logic uses only the synchronised copies.
- **Debounce FSMs:** one per button, with an N-bit down-counter `cnt` and these states:
  - ZERO: if input = 1, go to WAIT1 and load `cnt` = 2^N−1.
  - WAIT1: if input = 0, go to ZERO. Otherwise, if `cnt` = 0, go to ONE and assert `tick` for that cycle. Otherwise decrement `cnt`.
  - ONE: if input = 0, go to WAIT0 and load `cnt` = 2^N−1.
  - WAIT0: if input = 1, go to ONE. Otherwise, if `cnt` = 0, go to ZERO. Otherwise decrement `cnt`.
  - Debounced level = 1 in ONE and in WAIT0.
  - `tick` is combinational and fires only on the WAIT1→ONE transition.
- **Output stage (registered):**
  - `wr` <= wr_tick & ~full
  - `wr_drop` <= wr_tick & full
  - `rd` <= rd_tick & ~empty
  - `rd_drop` <= rd_tick & empty
  - On wr_tick, `w_data` <= synchronised `sw`; otherwise `w_data` holds.
- **Simultaneous events:**
  - wr_tick and rd_tick in the same cycle: each is handled independently, so both strobes may assert together.
  - full and empty are sampled in the tick cycle only.
- **Repeat presses:** a button held indefinitely produces exactly one strobe. A new strobe requires release (through WAIT0 to ZERO) followed by a fresh press. Strobes from one button are therefore at least 2^N+1 cycles apart, so the one-cycle lag of the FIFO flags cannot cause an overflow.
- **Reset:** asynchronous, at any time, including mid-debounce.
  - Both FSMs go to ZERO, all counters to 0, and synchronisers to 0.
  - `wr`, `rd`, `wr_drop`, `rd_drop`, `db_wr`, `db_rd` = 0; `w_data` = 0.
  - A button held through reset release is debounced afresh and produces one strobe.

## Timing
- **Press latency:** with the raw input stable high from rising edge e0, the FSM enters WAIT1 at e2 and the tick occurs in the cycle after e(2^N+1). `wr`/`rd` are high for exactly the one cycle after e(2^N+2).
- **Glitches:** a glitch shorter than 2^N cycles never produces a strobe, and a release glitch shorter than 2^N cycles does not re-arm the FSM.
- **Data capture:** `w_data` is sampled in the same cycle as the decision to raise `wr`, and is stable while `wr` = 1.
- **Registered outputs:** all outputs are registered, so there is no combinational path from input to output.

## Structure
- Shared package `fifo_ctrl_pkg` holds:
  - the debounce state encoding (ZERO = 2'b00, WAIT1 = 2'b01, ONE = 2'b10, WAIT0 = 2'b11);
  - the default `N` and `B` constants.
- Sub-module `btn_db_fsm` contains one synchroniser, one FSM and one counter, with outputs `db_level` and `db_tick`. It is instantiated twice (write, read).
- The top level holds the `sw` synchroniser, the gating logic and the output registers.

## Test plan
All scenarios use N = 3 and B = 3.
- **Clean press:** hold `btn_wr` = 1 from e0 with `sw` = 3'b101 and `full` = 0 → `wr` high for one cycle after e10, `w_data` = 5; no second strobe while the button stays held.
- **Bounce:** `btn_rd` toggles 1,0,1,0 at 2-cycle spacing, then stays high with `empty` = 0 → a single `rd` pulse, 10 edges after the final rising transition.
- **Overflow guard:** write press with `full` = 1 → `wr` stays 0, `wr_drop` pulses once, `w_data` updates. Read press with `empty` = 1 → `rd_drop` pulses once, `rd` stays 0.
- **Simultaneous:** both buttons rise on the same edge, `full` = `empty` = 0 → `wr` and `rd` assert in the same cycle.
- **Reset mid-debounce:** assert `reset` at edge 5 of a write press for 2 cycles, holding the button → all outputs are 0 during reset; a single `wr` pulse follows 10 edges after reset release.
- **Release and re-press:** release for 4 cycles, then press again → no strobe, because the FSM is still in WAIT0 and returns to ONE. Release for 12 cycles, then press → a second `wr` pulse.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared types and defaults for the cola_fifo button front-end.
// Debounce state encoding is fixed so the level output is simply state bit 1.
package fifo_ctrl_pkg;

    localparam int unsigned DbCntWidth = 20;
    localparam int unsigned DataWidth  = 3;

    typedef enum logic [1:0] {
        StZero  = 2'b00,
        StWait1 = 2'b01,
        StOne   = 2'b10,
        StWait0 = 2'b11
    } db_state_e;

    // Debounced level is high while settled high or waiting out a release.
    function automatic logic db_level_of(db_state_e state);
        return (state == StOne) || (state == StWait0);
    endfunction

endpackage

// File: rtl/btn_db_fsm.sv
// One push-button path: 2-flop synchroniser, debounce FSM and stable-time counter.
// db_tick_o is combinational and fires only on the WAIT1 -> ONE transition.
module btn_db_fsm
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned N = DbCntWidth
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic db_level_o,
    output logic db_tick_o
);

    localparam logic [N-1:0] CntOne = N'(1);

    logic [1:0]   sync_q;
    logic         btn_s;
    db_state_e    state_q, state_d;
    logic [N-1:0] cnt_q, cnt_d;
    logic         tick;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q  <= 2'b00;
            state_q <= StZero;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[0], btn_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick    = 1'b0;
        unique case (state_q)
            StZero: begin
                if (btn_s) begin
                    state_d = StWait1;
                    cnt_d   = '1;
                end
            end
            StWait1: begin
                if (!btn_s) begin
                    state_d = StZero;
                end else if (cnt_q == '0) begin
                    state_d = StOne;
                    tick    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StOne: begin
                if (!btn_s) begin
                    state_d = StWait0;
                    cnt_d   = '1;
                end
            end
            StWait0: begin
                if (btn_s) begin
                    state_d = StOne;
                end else if (cnt_q == '0) begin
                    state_d = StZero;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
        endcase
    end

    assign db_level_o = db_level_of(state_q);
    assign db_tick_o  = tick;

endmodule

// File: rtl/fifo_btn_ctrl.sv
// Button front-end for cola_fifo: debounced single-cycle wr/rd strobes with
// overflow/underflow suppression and capture of the synchronised switch word.
module fifo_btn_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned N = DbCntWidth,
    parameter int unsigned B = DataWidth
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         btn_wr_i,
    input  logic         btn_rd_i,
    input  logic [B-1:0] sw_i,
    input  logic         full_i,
    input  logic         empty_i,
    output logic         wr_o,
    output logic         rd_o,
    output logic [B-1:0] w_data_o,
    output logic         wr_drop_o,
    output logic         rd_drop_o,
    output logic         db_wr_o,
    output logic         db_rd_o
);

    logic         wr_tick, rd_tick;
    logic [B-1:0] sw_meta_q, sw_sync_q;
    logic         wr_q, wr_d, rd_q, rd_d;
    logic         wr_drop_q, wr_drop_d, rd_drop_q, rd_drop_d;
    logic [B-1:0] w_data_q, w_data_d;

    btn_db_fsm #(
        .N (N)
    ) u_db_wr (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .btn_i      (btn_wr_i),
        .db_level_o (db_wr_o),
        .db_tick_o  (wr_tick)
    );

    btn_db_fsm #(
        .N (N)
    ) u_db_rd (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .btn_i      (btn_rd_i),
        .db_level_o (db_rd_o),
        .db_tick_o  (rd_tick)
    );

    // Full/empty only matter in the tick cycle; write and read are gated independently.
    always_comb begin
        wr_d      = wr_tick & ~full_i;
        wr_drop_d = wr_tick & full_i;
        rd_d      = rd_tick & ~empty_i;
        rd_drop_d = rd_tick & empty_i;
        w_data_d  = w_data_q;
        if (wr_tick) begin
            w_data_d = sw_sync_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            wr_drop_q <= 1'b0;
            rd_drop_q <= 1'b0;
            w_data_q  <= '0;
        end else begin
            sw_meta_q <= sw_i;
            sw_sync_q <= sw_meta_q;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            wr_drop_q <= wr_drop_d;
            rd_drop_q <= rd_drop_d;
            w_data_q  <= w_data_d;
        end
    end

    assign wr_o      = wr_q;
    assign rd_o      = rd_q;
    assign wr_drop_o = wr_drop_q;
    assign rd_drop_o = rd_drop_q;
    assign w_data_o  = w_data_q;

endmodule
